// File: rtl/ram_copy_engine_pkg.sv
// rtl/ram_copy_engine_pkg.sv - shared state encodings, mode constants and default widths
package ram_copy_engine_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 16;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FILL  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_copy_counter.sv
// rtl/ram_copy_counter.sv - word index register with clear, increment and last-word compare
module ram_copy_counter
    import ram_copy_engine_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] idx,
    output logic              last
);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // len is one bit wider than idx so a full-RAM count (2**ADDR_W) still compares correctly
    assign idx  = idx_q;
    assign last = ({1'b0, idx_q} == (len - 1'b1));

endmodule

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - block copy / fill initiator for a single-port combinational-read RAM
module ram_copy_engine
    import ram_copy_engine_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic [ADDR_W-1:0] idx;
    logic              last;

    ram_copy_counter #(.ADDR_W(ADDR_W)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .len   (len_q),
        .idx   (idx),
        .last  (last)
    );

    // Outputs are computed for the next state so every pin comes straight from a flop
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        data_d  = data_q;
        addr_d  = addr_q;
        load_d  = 1'b0;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    fill_d  = fill_value;
                    cnt_clr = 1'b1;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else if (mode == MODE_COPY) begin
                        state_d = ST_READ;
                        addr_d  = src;
                    end else begin
                        state_d = ST_FILL;
                        addr_d  = dst;
                        data_d  = fill_value;
                        load_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
                data_d  = ram_out;
                addr_d  = dst_q + idx;
                load_d  = 1'b1;
            end
            ST_WRITE: begin
                if (last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_READ;
                    cnt_inc = 1'b1;
                    addr_d  = src_q + idx + 1'b1;
                end
            end
            ST_FILL: begin
                if (last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    addr_d  = dst_q + idx + 1'b1;
                    data_d  = fill_q;
                    load_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_address = addr_q;
    assign ram_load    = load_q;
    assign ram_in      = data_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - directed self-checking bench for ram_copy_engine
module tb_ram_copy_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [13:0] src = '0;
    logic [13:0] dst = '0;
    logic [14:0] len = '0;
    logic [15:0] fill_value = '0;
    logic        busy;
    logic        done;
    logic [13:0] ram_address;
    logic        ram_load;
    logic [15:0] ram_in;
    logic [15:0] ram_out;

    logic [15:0] mem [0:16383];
    logic        pre_we = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ram_copy_engine dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .fill_value  (fill_value),
        .busy        (busy),
        .done        (done),
        .ram_address (ram_address),
        .ram_load    (ram_load),
        .ram_in      (ram_in),
        .ram_out     (ram_out)
    );

    // RAM model; the external port mux holds the write strobe off while reset is asserted
    assign ram_out = mem[ram_address];
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_load && !reset) begin
            mem[ram_address] <= ram_in;
        end
    end

    task automatic poke(input logic [13:0] a, input logic [15:0] v);
        @(negedge clk);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic run_op(input logic m, input logic [13:0] s, input logic [13:0] d,
                          input logic [14:0] l, input logic [15:0] f, input int n,
                          output logic [31:0] bm, output logic [31:0] dm, output logic [31:0] lm);
        @(negedge clk);
        mode = m; src = s; dst = d; len = l; fill_value = f; start = 1'b1;
        bm = '0; dm = '0; lm = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            bm[c] = busy;
            dm[c] = done;
            lm[c] = ram_load;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (ram_load !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", ram_load); end
        total++; if (ram_address !== 14'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", ram_address); end
        total++; if (ram_in !== 16'h0) begin bad++; $display("FAIL reset_in got=%h exp=0000", ram_in); end
        reset = 1'b0;
    endtask

    task automatic test_copy4;
        logic [31:0] bm, dm, lm;
        logic [15:0] exp_v [4];
        exp_v = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int k = 0; k < 4; k++) begin
            poke(14'h0010 + 14'(k), exp_v[k]);
            poke(14'h0100 + 14'(k), 16'h0000);
        end
        run_op(1'b0, 14'h0010, 14'h0100, 15'd4, 16'h0, 11, bm, dm, lm);
        total++; if (bm !== 32'h1FE) begin bad++; $display("FAIL copy4_busy got=%h exp=%h", bm, 32'h1FE); end
        total++; if (dm !== 32'h200) begin bad++; $display("FAIL copy4_done got=%h exp=%h", dm, 32'h200); end
        total++; if (lm !== 32'h154) begin bad++; $display("FAIL copy4_load got=%h exp=%h", lm, 32'h154); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem[14'h0100 + 14'(k)] !== exp_v[k]) begin
                bad++; $display("FAIL copy4_dst[%0d] got=%h exp=%h", k, mem[14'h0100 + 14'(k)], exp_v[k]);
            end
            total++;
            if (mem[14'h0010 + 14'(k)] !== exp_v[k]) begin
                bad++; $display("FAIL copy4_src[%0d] got=%h exp=%h", k, mem[14'h0010 + 14'(k)], exp_v[k]);
            end
        end
    endtask

    task automatic test_fill_wrap;
        logic [31:0] bm, dm, lm;
        poke(14'h3FFE, 16'h0000);
        poke(14'h3FFF, 16'h0000);
        poke(14'h0000, 16'h0000);
        poke(14'h0001, 16'h1234);
        run_op(1'b1, 14'h0000, 14'h3FFE, 15'd3, 16'hBEEF, 7, bm, dm, lm);
        total++; if (bm !== 32'hE) begin bad++; $display("FAIL fill_busy got=%h exp=%h", bm, 32'hE); end
        total++; if (dm !== 32'h10) begin bad++; $display("FAIL fill_done got=%h exp=%h", dm, 32'h10); end
        total++; if (lm !== 32'hE) begin bad++; $display("FAIL fill_load got=%h exp=%h", lm, 32'hE); end
        total++; if (mem[14'h3FFE] !== 16'hBEEF) begin bad++; $display("FAIL fill_3ffe got=%h exp=beef", mem[14'h3FFE]); end
        total++; if (mem[14'h3FFF] !== 16'hBEEF) begin bad++; $display("FAIL fill_3fff got=%h exp=beef", mem[14'h3FFF]); end
        total++; if (mem[14'h0000] !== 16'hBEEF) begin bad++; $display("FAIL fill_wrap0 got=%h exp=beef", mem[14'h0000]); end
        total++; if (mem[14'h0001] !== 16'h1234) begin bad++; $display("FAIL fill_untouched got=%h exp=1234", mem[14'h0001]); end
    endtask

    task automatic test_len0;
        logic [31:0] bm, dm, lm;
        for (int m = 0; m < 2; m++) begin
            run_op(1'(m), 14'h0010, 14'h0100, 15'd0, 16'hFFFF, 4, bm, dm, lm);
            total++; if (dm !== 32'h2) begin bad++; $display("FAIL len0_done mode=%0d got=%h exp=%h", m, dm, 32'h2); end
            total++; if (bm !== 32'h0) begin bad++; $display("FAIL len0_busy mode=%0d got=%h exp=0", m, bm); end
            total++; if (lm !== 32'h0) begin bad++; $display("FAIL len0_load mode=%0d got=%h exp=0", m, lm); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] bm, dm, lm;
        poke(14'h0010, 16'h1111);
        poke(14'h0011, 16'h2222);
        poke(14'h0200, 16'h0000);
        poke(14'h0201, 16'h0000);
        poke(14'h0300, 16'h0000);
        poke(14'h0310, 16'h0000);
        @(negedge clk);
        mode = 1'b0; src = 14'h0010; dst = 14'h0200; len = 15'd2; start = 1'b1;
        bm = '0; dm = '0; lm = '0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bm[c] = busy;
            dm[c] = done;
            lm[c] = ram_load;
            if (c == 1 || c == 3 || c == 6) start = 1'b0;
            if (c == 2) begin
                mode = 1'b1; src = 14'h0040; dst = 14'h0300; len = 15'd1; fill_value = 16'h5555; start = 1'b1;
            end
            if (c == 5) begin
                mode = 1'b1; dst = 14'h0310; len = 15'd1; fill_value = 16'h7777; start = 1'b1;
            end
        end
        total++; if (bm !== 32'h5E) begin bad++; $display("FAIL b2b_busy got=%h exp=%h", bm, 32'h5E); end
        total++; if (dm !== 32'hA0) begin bad++; $display("FAIL b2b_done got=%h exp=%h", dm, 32'hA0); end
        total++; if (lm !== 32'h54) begin bad++; $display("FAIL b2b_load got=%h exp=%h", lm, 32'h54); end
        total++; if (mem[14'h0200] !== 16'h1111) begin bad++; $display("FAIL b2b_dst0 got=%h exp=1111", mem[14'h0200]); end
        total++; if (mem[14'h0201] !== 16'h2222) begin bad++; $display("FAIL b2b_dst1 got=%h exp=2222", mem[14'h0201]); end
        total++; if (mem[14'h0300] !== 16'h0000) begin bad++; $display("FAIL b2b_ignored got=%h exp=0000", mem[14'h0300]); end
        total++; if (mem[14'h0310] !== 16'h7777) begin bad++; $display("FAIL b2b_second got=%h exp=7777", mem[14'h0310]); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] bm, dm, lm;
        logic [15:0] exp_v [4];
        exp_v = '{16'h1111, 16'hDEAD, 16'hDEAD, 16'hDEAD};
        poke(14'h0010, 16'h1111);
        poke(14'h0011, 16'h2222);
        poke(14'h0012, 16'h3333);
        poke(14'h0013, 16'h4444);
        for (int k = 0; k < 4; k++) poke(14'h0100 + 14'(k), 16'hDEAD);
        @(negedge clk);
        mode = 1'b0; src = 14'h0010; dst = 14'h0100; len = 15'd4; start = 1'b1;
        bm = '0; dm = '0; lm = '0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bm[c] = busy;
            dm[c] = done;
            lm[c] = ram_load;
            if (c == 1) start = 1'b0;
            if (c == 4) reset = 1'b1;
            if (c == 5) begin
                total++; if (ram_address !== 14'h0) begin bad++; $display("FAIL rstmid_addr got=%h exp=0000", ram_address); end
                reset = 1'b0;
            end
        end
        total++; if (bm !== 32'h1E) begin bad++; $display("FAIL rstmid_busy got=%h exp=%h", bm, 32'h1E); end
        total++; if (dm !== 32'h0) begin bad++; $display("FAIL rstmid_done got=%h exp=0", dm); end
        total++; if (lm !== 32'h14) begin bad++; $display("FAIL rstmid_load got=%h exp=%h", lm, 32'h14); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem[14'h0100 + 14'(k)] !== exp_v[k]) begin
                bad++; $display("FAIL rstmid_dst[%0d] got=%h exp=%h", k, mem[14'h0100 + 14'(k)], exp_v[k]);
            end
        end
    endtask

    task automatic test_overlap;
        logic [31:0] bm, dm, lm;
        poke(14'h0020, 16'hAAAA);
        poke(14'h0021, 16'h0001);
        poke(14'h0022, 16'h0002);
        poke(14'h0023, 16'h0003);
        run_op(1'b0, 14'h0020, 14'h0021, 15'd3, 16'h0, 9, bm, dm, lm);
        total++; if (bm !== 32'h7E) begin bad++; $display("FAIL overlap_busy got=%h exp=%h", bm, 32'h7E); end
        total++; if (dm !== 32'h80) begin bad++; $display("FAIL overlap_done got=%h exp=%h", dm, 32'h80); end
        total++; if (lm !== 32'h54) begin bad++; $display("FAIL overlap_load got=%h exp=%h", lm, 32'h54); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem[14'h0020 + 14'(k)] !== 16'hAAAA) begin
                bad++; $display("FAIL overlap_mem[%0d] got=%h exp=aaaa", k, mem[14'h0020 + 14'(k)]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_copy4();
        test_fill_wrap();
        test_len0();
        test_back_to_back();
        test_reset_mid();
        test_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Bus initiator for the single-port word RAM (RAM16K-class: combinational read, write on posedge clk when load=1).
- Performs block copy (read-then-write per word) or block fill (constant write) over a contiguous address range, driving the RAM's load/address/in pins and sampling its out pin.
- Sits beside the CPU and muxes onto the data-memory port while busy; the arbitration mux is outside this block.

Parameters:
- ADDR_W, 14, RAM address width; all address arithmetic is modulo 2**ADDR_W.
- DATA_W, 16, RAM word width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill; latched on accepted start.
- src  input  ADDR_W  copy source base; latched on start; ignored for fill.
- dst  input  ADDR_W  destination base; latched on start.
- len  input  ADDR_W+1  word count, 0..2**ADDR_W; latched on start.
- fill_value  input  DATA_W  fill word; latched on start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- ram_address  output  ADDR_W  to RAM address.
- ram_load  output  1  to RAM load.
- ram_in  output  DATA_W  to RAM in (write data).
- ram_out  input  DATA_W  from RAM out (combinational read data).

Behaviour:
- Reset, at the next rising edge: state IDLE; busy=0, done=0, ram_load=0, ram_address=0, ram_in=0; index and latched operands cleared.
- Reset mid-operation aborts at that edge. Words already written stay written. No done pulse.
- Outputs are decoded from registered state only (Moore); there are no combinational paths from inputs to outputs.
- States: IDLE, READ, WRITE, FILL.
- IDLE: busy=0, ram_load=0. On start=1, latch the operands and set index i=0. Next state:
  - len=0: stay IDLE and pulse done next cycle.
  - mode=0: READ.
  - mode=1: FILL.
- READ: ram_address=src+i, ram_load=0. At the edge, capture ram_out into data_q, then go to WRITE.
- WRITE: ram_address=dst+i, ram_in=data_q, ram_load=1. At the edge:
  - if i==len-1: go to IDLE with done=1;
  - else: i=i+1 and go to READ.
- FILL: ram_address=dst+i, ram_in=fill_value(latched), ram_load=1. At the edge:
  - if i==len-1: go to IDLE with done=1;
  - else: i=i+1 and stay in FILL.
- busy=1 in READ, WRITE and FILL.
- done=1 for exactly the one cycle after the final write edge, while state is IDLE.
- Latency, with start accepted in cycle 0:
  - copy: done in cycle 2*len+1;
  - fill: done in cycle len+1;
  - len=0: done in cycle 1.
- start while busy is ignored; it is neither queued nor does it alter the latched operands.
- start in the done cycle is accepted (state is IDLE).
- Address wrap: src+i and dst+i truncate to ADDR_W bits. len=2**ADDR_W covers the whole RAM.
- Overlap: copy is strictly ascending, one word at a time. If dst lies in (src, src+len), earlier writes propagate forward. This is defined behaviour and is not corrected.
- In IDLE, ram_address holds its last value and ram_in holds its last value. ram_load must be 0.

Decomposition:
- Shared include header holds:
  - state encodings (IDLE=2'd0, READ=2'd1, WRITE=2'd2, FILL=2'd3);
  - MODE_COPY/MODE_FILL constants;
  - default ADDR_W/DATA_W.
- One natural sub-module, ram_copy_counter: index register with clear, increment and the last-word compare (i==len-1). It is reused later by a planned RAM scan/compare engine.

Test Plan:
- Copy 4 words, src=0x0010, dst=0x0100, RAM[0x10..0x13]=0x1111,0x2222,0x3333,0x4444 -> RAM[0x100..0x103] match; source unchanged; done only in cycle 9; busy cycles 1-8; ram_load high only in cycles 2,4,6,8.
- Fill len=3, dst=0x3FFE, fill_value=0xBEEF -> 0x3FFE, 0x3FFF and 0x0000 (wrap) = 0xBEEF; 0x0001 untouched; done in cycle 4.
- len=0, either mode -> done in cycle 1; ram_load never asserted; busy never asserted.
- Start pulse with changed operands while busy -> ignored, original operation completes unchanged. Start asserted in the done cycle -> new operation begins and busy=1 next cycle.
- Reset asserted in cycle 4 of the 4-word copy above -> only 0x100 written (0x1111); busy=0, done=0, ram_load=0 from cycle 5; 0x101..0x103 keep prior contents.
- Overlapping copy src=0x20, dst=0x21, len=3, RAM[0x20]=0xAAAA -> RAM[0x21..0x23] all 0xAAAA; done in cycle 7.
